// File: rtl/spi_cmd_rx.sv
// rtl/spi_cmd_rx.sv - SPI mode-0 command receiver with a vblank-gated commit buffer.
module spi_cmd_rx #(
    parameter int CMD_W  = 4,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sclk,
    input  logic              i_mosi,
    input  logic              i_ss_n,
    input  logic              i_vblank,
    output logic [CMD_W-1:0]  o_cmd,
    output logic [DATA_W-1:0] o_data,
    output logic              o_load,
    output logic              o_pending,
    output logic              o_overrun
);

    localparam int F  = CMD_W + DATA_W;
    localparam int CW = $clog2(F + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic mosi_s1_q, mosi_s2_q;
    logic ss_s1_q, ss_s2_q;
    logic rise;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [F-1:0]  sh_q, sh_d;
    logic          complete;

    logic [F-1:0]      buf_q;
    logic              pending_q, load_q, overrun_q;
    logic [CMD_W-1:0]  cmd_q;
    logic [DATA_W-1:0] data_q;
    logic              commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            ss_s1_q   <= 1'b1;
            ss_s2_q   <= 1'b1;
        end else begin
            sclk_s1_q <= i_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= i_mosi;
            mosi_s2_q <= mosi_s1_q;
            ss_s1_q   <= i_ss_n;
            ss_s2_q   <= ss_s1_q;
        end
    end

    assign rise = sclk_s2_q & ~sclk_s3_q;

    // Completion is judged before the select check so a frame whose last bit
    // has already landed is not lost if ss_n rises in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        complete = (state_q == S_SHIFT) && (cnt_q == CW'(F));
        if (ss_s2_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SHIFT;
                    if (rise) begin
                        sh_d  = {sh_q[F-2:0], mosi_s2_q};
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_SHIFT: begin
                    if (complete) begin
                        state_d = S_DONE;
                    end else if (rise) begin
                        sh_d  = {sh_q[F-2:0], mosi_s2_q};
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = S_DONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    // Gating with load_q keeps loads at least one cycle apart.
    assign commit = pending_q & i_vblank & ~load_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            load_q    <= 1'b0;
            cmd_q     <= '0;
            data_q    <= '0;
        end else begin
            load_q <= commit;
            if (commit) begin
                cmd_q  <= buf_q[F-1:DATA_W];
                data_q <= buf_q[DATA_W-1:0];
            end
            if (complete) begin
                buf_q     <= sh_q;
                pending_q <= 1'b1;
                overrun_q <= pending_q & ~commit;
            end else begin
                overrun_q <= 1'b0;
                if (commit) begin
                    pending_q <= 1'b0;
                end
            end
        end
    end

    assign o_cmd     = cmd_q;
    assign o_data    = data_q;
    assign o_load    = load_q;
    assign o_pending = pending_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// tb/tb_spi_cmd_rx.sv - scoreboard bench for spi_cmd_rx.
module tb_spi_cmd_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk, mosi, ss_n, vblank;
    logic [3:0]  cmd;
    logic [23:0] data;
    logic        load, pending, overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int n_loads  = 0;
    int n_ovr    = 0;
    logic load_prev = 1'b0;
    logic [27:0] exp_q[$];

    spi_cmd_rx #(.CMD_W(4), .DATA_W(24)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sclk   (sclk),
        .i_mosi   (mosi),
        .i_ss_n   (ss_n),
        .i_vblank (vblank),
        .o_cmd    (cmd),
        .o_data   (data),
        .o_load   (load),
        .o_pending(pending),
        .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (overrun) n_ovr++;
        if (load) begin
            n_loads++;
            check("load_gap", {31'd0, load_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_load", 32'd1, 32'd0);
            end else begin
                logic [27:0] e;
                e = exp_q.pop_front();
                check("load_cmd", {28'd0, cmd}, {28'd0, e[27:24]});
                check("load_data", {8'd0, data}, {8'd0, e[23:0]});
            end
        end
        load_prev = load;
    end

    task automatic send_bits(input logic [63:0] val, input int n);
        ss_n = 1'b0;
        #40;
        for (int i = 0; i < n; i++) begin
            mosi = val[n-1-i];
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
        #40 ss_n = 1'b1;
        #80;
    endtask

    task automatic wait_loads(input int target);
        for (int i = 0; i < 200 && n_loads < target; i++) @(negedge clk);
        check("load_count", n_loads, target);
    endtask

    initial begin
        int base_ovr;
        rst_n = 1'b0;
        vblank = 1'b0;
        sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            sclk = 1'($urandom); mosi = 1'($urandom); ss_n = 1'($urandom);
            vblank = 1'($urandom);
        end
        sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1; vblank = 1'b0;
        @(negedge clk);
        check("rst_cmd", {28'd0, cmd}, 32'd0);
        check("rst_data", {8'd0, data}, 32'd0);
        check("rst_load", {31'd0, load}, 32'd0);
        check("rst_pending", {31'd0, pending}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_no_load", n_loads, 0);

        // basic frame, committed on vblank
        send_bits({36'd0, 28'h5A5C3F0}, 28);
        check("basic_pending", {31'd0, pending}, 32'd1);
        check("basic_no_load", n_loads, 0);
        exp_q.push_back(28'h5A5C3F0);
        vblank = 1'b1;
        wait_loads(1);
        repeat (5) @(negedge clk);
        vblank = 1'b0;
        check("basic_pending_clr", {31'd0, pending}, 32'd0);
        check("basic_one_load", n_loads, 1);

        // short frame dropped, then a good frame
        send_bits({44'd0, 20'hABCDE}, 20);
        check("short_pending", {31'd0, pending}, 32'd0);
        send_bits({36'd0, 28'h2000001}, 28);
        check("short_next_pending", {31'd0, pending}, 32'd1);
        exp_q.push_back(28'h2000001);
        vblank = 1'b1;
        wait_loads(2);
        vblank = 1'b0;

        // overrun: A replaced by B
        base_ovr = n_ovr;
        send_bits({36'd0, 28'h1111111}, 28);
        send_bits({36'd0, 28'h2222222}, 28);
        check("ovr_pulses", n_ovr - base_ovr, 1);
        exp_q.push_back(28'h2222222);
        vblank = 1'b1;
        wait_loads(3);
        repeat (10) @(negedge clk);
        vblank = 1'b0;
        check("ovr_single_load", n_loads, 3);

        // long frame: only the first 28 bits are kept
        send_bits({28'd0, 28'h93C5A7E, 8'hFF}, 36);
        check("long_pending", {31'd0, pending}, 32'd1);
        exp_q.push_back(28'h93C5A7E);
        vblank = 1'b1;
        wait_loads(4);

        // back-to-back frames while vblank stays high
        base_ovr = n_ovr;
        exp_q.push_back(28'h7123456);
        send_bits({36'd0, 28'h7123456}, 28);
        exp_q.push_back(28'hEFEDCBA);
        send_bits({36'd0, 28'hEFEDCBA}, 28);
        wait_loads(6);
        check("vb_no_overrun", n_ovr - base_ovr, 0);
        check("vb_queue_empty", exp_q.size(), 0);
        vblank = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
